// File: rtl/velocity_ring_pkg.sv
// Shared constants for the velocity ring: fragment layout, null fragment and
// controller state encoding.
package velocity_ring_pkg;

   localparam int FRAG_W   = 106;
   localparam int CELL_W   = 8;
   localparam int NULL_BIT = 96;
   localparam int ADDR_LSB = 97;

   localparam logic [FRAG_W-1:0] NULL_FRAG = FRAG_W'(1) << NULL_BIT;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_INJECT = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   function automatic logic [FRAG_W-ADDR_LSB-1:0] frag_addr(input logic [FRAG_W-1:0] frag);
      return frag[FRAG_W-1:ADDR_LSB];
   endfunction

endpackage

// File: rtl/velocity_slot_timer.sv
// Free-running slot phase counter; resets to the last phase so it stays in
// lock-step with the ring nodes, which share the same reset.
module velocity_slot_timer #(
   parameter int SLOT_LEN = 16,
   parameter int PH_W     = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PH_W-1:0] phase,
   output logic            boundary
);

   assign boundary = (phase == PH_W'(SLOT_LEN - 1));

   always_ff @(posedge clk) begin
      if (reset)
         phase <= PH_W'(SLOT_LEN - 1);
      else if (boundary)
         phase <= '0;
      else
         phase <= phase + 1'b1;
   end

endmodule

// File: rtl/velocity_ring_ctrl.sv
// Velocity ring sequencer: accepts one fragment per source per slot on the
// boundary, holds it on the injection buses for a full slot, then waits for drain.
module velocity_ring_ctrl
   import velocity_ring_pkg::*;
#(
   parameter int NNODES      = 8,
   parameter int SLOT_LEN    = 16,
   parameter int DRAIN_SLOTS = 4,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              inject_done,
   input  logic              ref_valid,
   output logic              ref_ready,
   input  logic [FRAG_W-1:0] ref_data,
   input  logic [CELL_W-1:0] ref_cell,
   input  logic              nei_valid,
   output logic              nei_ready,
   input  logic [FRAG_W-1:0] nei_data,
   input  logic [CELL_W-1:0] nei_cell,
   input  logic [NNODES-1:0] node_rempty,
   output logic [FRAG_W-1:0] inj_ref,
   output logic [CELL_W-1:0] inj_ref_cell,
   output logic [NNODES-1:0] inj_ref_sel,
   output logic [FRAG_W-1:0] inj_nei,
   output logic [CELL_W-1:0] inj_nei_cell,
   output logic [NNODES-1:0] inj_nei_sel,
   output logic [3:0]        slot_phase,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  ref_count,
   output logic [CNT_W-1:0]  nei_count,
   output logic [1:0]        state
);

   localparam int SEL_W = $clog2(NNODES);
   localparam int DC_W  = $clog2(DRAIN_SLOTS + 1);

   logic            boundary;
   logic [DC_W-1:0] drain_cnt;
   logic [NNODES-1:0] ref_sel_next, nei_sel_next;

   velocity_slot_timer #(.SLOT_LEN(SLOT_LEN), .PH_W(4)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .phase    (slot_phase),
      .boundary (boundary)
   );

   // Handshake: a fragment moves when valid && ready; ready only rises on the
   // boundary cycle while injecting, so at most one transfer per source per slot.
   assign ref_ready = (state == ST_INJECT) && boundary;
   assign nei_ready = (state == ST_INJECT) && boundary;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

   always_comb begin
      ref_sel_next = '0;
      nei_sel_next = '0;
      ref_sel_next[ref_cell[SEL_W-1:0]] = 1'b1;
      nei_sel_next[nei_cell[SEL_W-1:0]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         drain_cnt    <= '0;
         inj_ref      <= NULL_FRAG;
         inj_ref_cell <= '0;
         inj_ref_sel  <= '0;
         inj_nei      <= NULL_FRAG;
         inj_nei_cell <= '0;
         inj_nei_sel  <= '0;
         ref_count    <= '0;
         nei_count    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_INJECT;
                  ref_count <= '0;
                  nei_count <= '0;
                  drain_cnt <= '0;
               end
            end
            ST_INJECT: begin
               if (boundary) begin
                  if (ref_valid) begin
                     inj_ref      <= ref_data;
                     inj_ref_cell <= ref_cell;
                     inj_ref_sel  <= ref_sel_next;
                     if (ref_count != '1) ref_count <= ref_count + 1'b1;
                  end else begin
                     inj_ref      <= NULL_FRAG;
                     inj_ref_cell <= '0;
                     inj_ref_sel  <= '0;
                  end
                  if (nei_valid) begin
                     inj_nei      <= nei_data;
                     inj_nei_cell <= nei_cell;
                     inj_nei_sel  <= nei_sel_next;
                     if (nei_count != '1) nei_count <= nei_count + 1'b1;
                  end else begin
                     inj_nei      <= NULL_FRAG;
                     inj_nei_cell <= '0;
                     inj_nei_sel  <= '0;
                  end
                  if (inject_done && !ref_valid && !nei_valid) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= '0;
                  end
               end
            end
            ST_DRAIN: begin
               // Completion needs DRAIN_SLOTS consecutive all-empty boundaries.
               if (boundary) begin
                  if (&node_rempty) begin
                     drain_cnt <= drain_cnt + 1'b1;
                     if (drain_cnt == DC_W'(DRAIN_SLOTS - 1)) state <= ST_DONE;
                  end else begin
                     drain_cnt <= '0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_velocity_ring_ctrl.sv
// Directed-plus-random bench for velocity_ring_ctrl with a slot-level model.
module tb_velocity_ring_ctrl;
   import velocity_ring_pkg::*;

   localparam int NN = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, start, inject_done;
   logic              ref_valid, nei_valid;
   logic [FRAG_W-1:0] ref_data, nei_data;
   logic [CELL_W-1:0] ref_cell, nei_cell;
   logic [NN-1:0]     node_rempty;

   logic              ref_ready, nei_ready, busy, done;
   logic [FRAG_W-1:0] inj_ref, inj_nei;
   logic [CELL_W-1:0] inj_ref_cell, inj_nei_cell;
   logic [NN-1:0]     inj_ref_sel, inj_nei_sel;
   logic [3:0]        slot_phase;
   logic [15:0]       ref_count, nei_count;
   logic [1:0]        state;

   logic              s_ref_ready, s_nei_ready, s_busy, s_done;
   logic [FRAG_W-1:0] s_inj_ref, s_inj_nei;
   logic [CELL_W-1:0] s_inj_ref_cell, s_inj_nei_cell;
   logic [NN-1:0]     s_inj_ref_sel, s_inj_nei_sel;
   logic [3:0]        s_slot_phase;
   logic [3:0]        s_ref_count, s_nei_count;
   logic [1:0]        s_state;

   velocity_ring_ctrl #(.NNODES(NN), .SLOT_LEN(16), .DRAIN_SLOTS(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .inject_done(inject_done),
      .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_data(ref_data), .ref_cell(ref_cell),
      .nei_valid(nei_valid), .nei_ready(nei_ready), .nei_data(nei_data), .nei_cell(nei_cell),
      .node_rempty(node_rempty),
      .inj_ref(inj_ref), .inj_ref_cell(inj_ref_cell), .inj_ref_sel(inj_ref_sel),
      .inj_nei(inj_nei), .inj_nei_cell(inj_nei_cell), .inj_nei_sel(inj_nei_sel),
      .slot_phase(slot_phase), .busy(busy), .done(done),
      .ref_count(ref_count), .nei_count(nei_count), .state(state)
   );

   velocity_ring_ctrl #(.NNODES(NN), .SLOT_LEN(16), .DRAIN_SLOTS(4), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .start(start), .inject_done(inject_done),
      .ref_valid(ref_valid), .ref_ready(s_ref_ready), .ref_data(ref_data), .ref_cell(ref_cell),
      .nei_valid(nei_valid), .nei_ready(s_nei_ready), .nei_data(nei_data), .nei_cell(nei_cell),
      .node_rempty(node_rempty),
      .inj_ref(s_inj_ref), .inj_ref_cell(s_inj_ref_cell), .inj_ref_sel(s_inj_ref_sel),
      .inj_nei(s_inj_nei), .inj_nei_cell(s_inj_nei_cell), .inj_nei_sel(s_inj_nei_sel),
      .slot_phase(s_slot_phase), .busy(s_busy), .done(s_done),
      .ref_count(s_ref_count), .nei_count(s_nei_count), .state(s_state)
   );

   int total = 0;
   int bad   = 0;
   int model_phase;
   bit exp_inject;
   int exp_ref_n, exp_nei_n;
   logic [FRAG_W-1:0] null_frag;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   // One clock; model_phase and exp_inject describe the state after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      model_phase = (model_phase + 1) % 16;
      chk("slot_phase", 128'(slot_phase), 128'(model_phase));
      chk("ref_ready", 128'(ref_ready), 128'(exp_inject && model_phase == 15));
      chk("nei_ready", 128'(nei_ready), 128'(exp_inject && model_phase == 15));
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; ref_valid = 1'b0; nei_valid = 1'b0; inject_done = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_phase = 15;
      exp_inject = 1'b0;
      exp_ref_n = 0;
      exp_nei_n = 0;
   endtask

   task automatic to_boundary();
      for (int i = 0; i < 16 && model_phase != 15; i++) tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_state"}, 128'(state), 128'(ST_IDLE));
      chk({tag, "_phase"}, 128'(slot_phase), 128'(15));
      chk({tag, "_inj_ref"}, 128'(inj_ref), 128'(null_frag));
      chk({tag, "_inj_nei"}, 128'(inj_nei), 128'(null_frag));
      chk({tag, "_sels"}, 128'({inj_ref_sel, inj_nei_sel}), 128'(0));
      chk({tag, "_cells"}, 128'({inj_ref_cell, inj_nei_cell}), 128'(0));
      chk({tag, "_ready"}, 128'({ref_ready, nei_ready}), 128'(0));
      chk({tag, "_busy_done"}, 128'({busy, done}), 128'(0));
      chk({tag, "_counts"}, 128'({ref_count, nei_count, s_ref_count}), 128'(0));
   endtask

   task automatic do_start();
      start = 1'b1;
      exp_inject = 1'b1;
      exp_ref_n = 0;
      exp_nei_n = 0;
      tick();
      start = 1'b0;
      chk("start_state", 128'(state), 128'(ST_INJECT));
      chk("start_busy", 128'(busy), 128'(1));
      chk("start_counts", 128'({ref_count, nei_count}), 128'(0));
   endtask

   // Called on a boundary cycle; drives that boundary, then checks the
   // following 16 cycles hold the expected bus contents.
   task automatic inject_slot(input bit rv, input bit nv, input bit idone,
                              input logic [7:0] rc, input logic [7:0] nc);
      logic [127:0]      r;
      logic [FRAG_W-1:0] rd, nd, er, en;
      logic [7:0]        erc, enc, ers, ens;
      r  = {$urandom, $urandom, $urandom, $urandom};
      rd = r[FRAG_W-1:0];
      r  = {$urandom, $urandom, $urandom, $urandom};
      nd = r[FRAG_W-1:0];
      ref_valid = rv; ref_data = rd; ref_cell = rc;
      nei_valid = nv; nei_data = nd; nei_cell = nc;
      inject_done = idone;
      er  = rv ? rd : null_frag;
      erc = rv ? rc : 8'd0;
      ers = rv ? (8'd1 << rc[2:0]) : 8'd0;
      en  = nv ? nd : null_frag;
      enc = nv ? nc : 8'd0;
      ens = nv ? (8'd1 << nc[2:0]) : 8'd0;
      if (rv) exp_ref_n++;
      if (nv) exp_nei_n++;
      tick();
      for (int k = 0; k < 16; k++) begin
         chk("inj_ref", 128'(inj_ref), 128'(er));
         chk("inj_ref_cell", 128'(inj_ref_cell), 128'(erc));
         chk("inj_ref_sel", 128'(inj_ref_sel), 128'(ers));
         chk("inj_nei", 128'(inj_nei), 128'(en));
         chk("inj_nei_cell", 128'(inj_nei_cell), 128'(enc));
         chk("inj_nei_sel", 128'(inj_nei_sel), 128'(ens));
         chk("inject_state", 128'(state), 128'(ST_INJECT));
         if (k < 15) begin
            ref_valid = 1'($urandom_range(0, 1));
            nei_valid = 1'($urandom_range(0, 1));
            ref_data  = ~ref_data;
            nei_cell  = 8'($urandom_range(0, 255));
            tick();
         end
      end
      chk("ref_count", 128'(ref_count), 128'(sat(exp_ref_n, 65535)));
      chk("nei_count", 128'(nei_count), 128'(sat(exp_nei_n, 65535)));
      chk("ref_count_sat", 128'(s_ref_count), 128'(sat(exp_ref_n, 15)));
   endtask

   // Called on a boundary cycle: ends injection, then waits for done.
   // Latency is counted from the DRAIN entry boundary.
   task automatic drain_and_wait(input int drop_at, input int exp_cycles);
      int n, b;
      bit got;
      ref_valid = 1'b0; nei_valid = 1'b0; inject_done = 1'b1; node_rempty = '1;
      exp_inject = 1'b0;
      tick();
      chk("drain_state", 128'(state), 128'(ST_DRAIN));
      chk("drain_buses", 128'({inj_ref_sel, inj_nei_sel, inj_ref_cell}), 128'(0));
      chk("drain_null", 128'(inj_ref ^ inj_nei), 128'(0));
      chk("drain_ref_null", 128'(inj_ref), 128'(null_frag));
      n = 1; b = 0; got = 1'b0;
      while (n < 400 && !got) begin
         if (model_phase == 15) begin
            b++;
            node_rempty = (b == drop_at) ? (8'hFF & ~(8'd1 << $urandom_range(0, 7))) : 8'hFF;
         end else begin
            node_rempty = 8'($urandom_range(0, 255));
         end
         tick();
         n++;
         if (done) got = 1'b1;
      end
      chk("done_latency", 128'(n), 128'(exp_cycles));
      chk("done_state", 128'(state), 128'(ST_DONE));
      tick();
      chk("done_pulse_end", 128'({done, busy}), 128'(0));
      chk("after_done_state", 128'(state), 128'(ST_IDLE));
      inject_done = 1'b0;
      node_rempty = '1;
   endtask

   initial begin
      int got_done;
      null_frag = NULL_FRAG;
      reset = 1'b1; start = 1'b0; inject_done = 1'b0;
      ref_valid = 1'b0; nei_valid = 1'b0; ref_data = '0; nei_data = '0;
      ref_cell = '0; nei_cell = '0; node_rempty = '1;
      do_reset();
      check_idle_outputs("reset");

      // Empty phase: start on a boundary, drain immediately.
      inject_done = 1'b1;
      do_start();
      to_boundary();
      drain_and_wait(0, 65);
      chk("empty_counts", 128'({ref_count, nei_count}), 128'(0));

      // Single reference fragment to cell 0x05, then an idle slot.
      do_start();
      to_boundary();
      inject_slot(1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
      chk("cell5_sel", 128'(exp_ref_n), 128'(1));
      inject_slot(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drain_and_wait(0, 65);
      chk("cell5_count_hold", 128'(ref_count), 128'(1));

      // Both sources for three boundaries, then random traffic; final
      // transfer lands on the inject_done boundary.
      do_start();
      to_boundary();
      for (int s = 0; s < 3; s++)
         inject_slot(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      for (int s = 0; s < 6; s++)
         inject_slot(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      inject_slot(1'b1, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      drain_and_wait(3, 113);
      chk("hold_ref_count", 128'(ref_count), 128'(exp_ref_n));
      chk("hold_nei_count", 128'(nei_count), 128'(exp_nei_n));

      // Saturation: 17 reference transfers.
      do_start();
      to_boundary();
      for (int s = 0; s < 17; s++)
         inject_slot(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'h00);
      drain_and_wait(0, 65);
      chk("sat_wide", 128'(ref_count), 128'(17));
      chk("sat_narrow", 128'(s_ref_count), 128'(15));

      // Reset in the middle of an injection slot.
      do_start();
      to_boundary();
      ref_valid = 1'b1; nei_valid = 1'b1; ref_cell = 8'h03; nei_cell = 8'h06;
      ref_data = {10'h155, 96'h0123_4567_89AB_CDEF_0011_2233};
      tick();
      ref_valid = 1'b0; nei_valid = 1'b0;
      tick();
      tick();
      chk("pre_reset_sel", 128'({inj_ref_sel, inj_nei_sel}), 128'({8'h08, 8'h40}));
      do_reset();
      check_idle_outputs("midreset");
      got_done = 0;
      node_rempty = '1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (done) got_done++;
      end
      chk("no_done_after_reset", 128'(got_done), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/velocity_ring_ctrl.md
# velocity_ring_ctrl

Sequencing controller for the velocity ring. It generates the shared 16-cycle slot timing, pulls reference and neighbor velocity fragments from two upstream sources, and drives them into the selected ring nodes at the correct slot phase. After injection ends it watches every node's empty flag and declares the phase complete once the ring has stayed drained for a set number of slots. It sits between the velocity-update source logic and the array of velocity ring nodes.

## Interface
- NNODES, 8: ring nodes driven; power of two.
- SLOT_LEN, 16: cycles per slot; must equal the ring node slot length.
- DRAIN_SLOTS, 4: consecutive all-empty slot boundaries required for completion; ≥2.
- CNT_W, 16: width of the accepted-fragment counters.
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high; shared with the ring nodes.
- start  in  1  begin a velocity phase; honoured in IDLE only.
- inject_done  in  1  level; no further source fragments will arrive.
- ref_valid / ref_ready  in / out  1  reference source handshake.
- ref_data  in  106  {addr[105:97], null[96], payload[95:0]}.
- ref_cell  in  8  destination cell of the reference fragment.
- nei_valid / nei_ready / nei_data / nei_cell  in / out / in / in  1/1/106/8  neighbor source; same format as the reference source.
- node_rempty  in  NNODES  per-node rempty.
- inj_ref, inj_ref_cell  out  106, 8  reference injection bus, broadcast to all nodes.
- inj_ref_sel  out  NNODES  one-hot node select for inj_ref. Unselected nodes see a null fragment.
- inj_nei, inj_nei_cell, inj_nei_sel  out  106, 8, NNODES  neighbor injection bus.
- slot_phase  out  4  current phase, 0..SLOT_LEN-1.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- ref_count, nei_count  out  CNT_W  fragments accepted this phase; saturating.

## Operation
- Null fragment (NULL_FRAG): bit 96 = 1, all other bits 0, cell 0.
- The slot timer counts SLOT_LEN-1, 0, 1, …, SLOT_LEN-1 and wraps. The boundary is phase == SLOT_LEN-1, which aligns with the node counter because both share reset.
- States:
  - IDLE: injection buses are null, sels are 0, ready is 0. start moves to INJECT and clears both counts.
  - INJECT:
    - ref_ready = nei_ready = 1 only on boundary cycles.
    - A transfer is valid && ready. The fragment latches into inj_* at the following cycle (phase 0) and is held for the whole slot.
    - The select is one-hot on cell[log2(NNODES)-1:0].
    - With no transfer at a boundary, that bus returns to null with sel = 0.
    - Each transfer increments its count; the count saturates at all-ones.
    - At a boundary with inject_done = 1 and neither valid asserted, the controller moves to DRAIN. The ready signals are still 1 on that cycle, but no transfer occurs.
  - DRAIN:
    - Buses are null. At each boundary, if &node_rempty, drain_cnt++; otherwise drain_cnt = 0.
    - When drain_cnt reaches DRAIN_SLOTS, the controller moves to DONE.
  - DONE: done = 1 for one cycle, then IDLE. The counts hold until the next start.
- Transfers landing on the inject_done boundary are accepted and keep the state in INJECT for one more slot.
- start outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, slot_phase SLOT_LEN-1, drain_cnt 0.
  - inj_* = NULL_FRAG, sels 0.
  - ready, busy, done 0; counts 0.
- Reset mid-phase aborts with no done pulse. Phase alignment with the nodes is preserved.
- Source-to-bus latency: 1 cycle (boundary → phase 0). The node samples reference at its counter 0 and neighbor at counter 1; both fall inside the held window.
- Throughput: at most one fragment per source per slot.
- node_rempty is sampled only at boundaries and ignored mid-slot.
- Minimum time from the DRAIN entry boundary to done: DRAIN_SLOTS·SLOT_LEN + 1 cycles.
- start on a boundary cycle: INJECT is entered next cycle, and the first ready comes at the next boundary.

## Structure
- Package velocity_ring_pkg:
  - FRAG_W = 106, CELL_W = 8, NULL_BIT = 96, ADDR_LSB = 97.
  - NULL_FRAG.
  - State enum {IDLE, INJECT, DRAIN, DONE}.
- One sub-module, velocity_slot_timer: phase counter with a boundary output, reset to SLOT_LEN-1. This block reuses it for alignment.

## Test plan
- Reset, then start with no source valids and inject_done = 1:
  - The first boundary enters DRAIN; all-empty nodes give done after 4·16 + 1 cycles.
  - Counts stay 0.
- Single ref fragment, cell 0x05, NNODES 8, at the first INJECT boundary:
  - inj_ref_sel = 8'b0010_0000 for phases 0..15 of the next slot, then null.
  - ref_count = 1.
- Both sources valid for 3 consecutive boundaries:
  - Three ref transfers and three nei transfers, each held exactly 16 cycles.
  - Valid held off-boundary gets no ready.
- In DRAIN, node_rempty drops to 0 at the 3rd boundary:
  - drain_cnt resets, and done is delayed by 3 further slots.
- reset asserted mid-INJECT with fragments on the buses:
  - Next cycle buses are null, state IDLE, slot_phase 15.
  - No done pulse.
- Counter saturation with CNT_W = 4, 17 ref transfers: ref_count = 15.
